// File: rtl/otl_cfg_pkg.sv
// rtl/otl_cfg_pkg.sv - shared helpers for OTL configuration register files
//
// Purpose : strobe-width and strobe/mask merge helpers, shared with the bus
//           adapters that build write strobes for these register files.
// Ports   : none (package).

package otl_cfg_pkg;

   // Widest register any user of mask_merge may pass; callers zero-extend
   // their operands to this width and take the low DATAW bits of the result.
   localparam int CFG_MAXW = 256;

   function automatic int strb_width(input int dataw);
      return dataw / 8;
   endfunction

   // A bit takes new_val only when its byte strobe is set and it is writable.
   function automatic logic [CFG_MAXW-1:0] mask_merge(
      input logic [CFG_MAXW-1:0]   old_val,
      input logic [CFG_MAXW-1:0]   new_val,
      input logic [CFG_MAXW/8-1:0] strb,
      input logic [CFG_MAXW-1:0]   wrmask
   );
      logic [CFG_MAXW-1:0] m;
      for (int b = 0; b < CFG_MAXW / 8; b++) begin
         m[b*8 +: 8] = {8{strb[b]}} & wrmask[b*8 +: 8];
      end
      return (old_val & ~m) | (new_val & m);
   endfunction

endpackage

// File: rtl/otl_cfg_reg.sv
// rtl/otl_cfg_reg.sv - one configuration register with strobe/mask merge
//
// Purpose : holds one register; loads RSTVAL on reset, merges host writes
//           through byte strobes and the writable-bit mask, and pulses upd_o
//           for one cycle after every accepted write with any strobe set.
// Ports   : clk, reset_n     clock, asynchronous active-low reset
//           we_i            write enable (address already decoded, in range)
//           wrdata_i        write data
//           wrstrb_i        byte enables
//           q_o             current register contents
//           upd_o           one-cycle update pulse

module otl_cfg_reg
   import otl_cfg_pkg::*;
#(
   parameter int               DATAW  = 32,
   parameter logic [DATAW-1:0] RSTVAL = '0,
   parameter logic [DATAW-1:0] WRMASK = '1
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        we_i,
   input  logic [DATAW-1:0]            wrdata_i,
   input  logic [strb_width(DATAW)-1:0] wrstrb_i,
   output logic [DATAW-1:0]            q_o,
   output logic                        upd_o
);

   logic [DATAW-1:0]    reg_q, reg_d;
   logic                upd_q, upd_d;
   logic [CFG_MAXW-1:0] merged;

   always_comb begin
      merged = mask_merge(CFG_MAXW'(reg_q), CFG_MAXW'(wrdata_i),
                          (CFG_MAXW/8)'(wrstrb_i), CFG_MAXW'(WRMASK));
      reg_d  = reg_q;
      upd_d  = 1'b0;
      // A write with all strobes clear is accepted but is not an update.
      if (we_i && (|wrstrb_i)) begin
         reg_d = merged[DATAW-1:0];
         upd_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reg_q <= RSTVAL;
         upd_q <= 1'b0;
      end else begin
         reg_q <= reg_d;
         upd_q <= upd_d;
      end
   end

   assign q_o   = reg_q;
   assign upd_o = upd_q;

endmodule

// File: rtl/otl_cfg_regfile.sv
// rtl/otl_cfg_regfile.sv - parametrised OTL configuration register file
//
// Purpose : DEPTH host-writable registers with byte strobes and per-bit write
//           masks, a one-deep registered read response channel, out-of-range
//           error reporting, and a flat live view of all registers.
// Ports   : clk, reset_n                  clock, asynchronous active-low reset
//           wraddr/wrdata/wrstrb/wrvalid  write channel (always ready)
//           wrready, wrerr                write accept, out-of-range pulse
//           rqaddr/rqvalid/rqready        read request channel
//           rddata/rderr/rdvalid/rdready  read response channel
//           mem_expose                    flat register contents
//           upd                           per-register update pulses

module otl_cfg_regfile
   import otl_cfg_pkg::*;
#(
   parameter int                     DATAW  = 32,
   parameter int                     ADDRW  = 4,
   parameter int                     DEPTH  = 16,
   parameter logic [DEPTH*DATAW-1:0] RSTVAL = '0,
   parameter logic [DEPTH*DATAW-1:0] WRMASK = '1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [ADDRW-1:0]             wraddr,
   input  logic [DATAW-1:0]             wrdata,
   input  logic [strb_width(DATAW)-1:0] wrstrb,
   input  logic                         wrvalid,
   output logic                         wrready,
   output logic                         wrerr,
   input  logic [ADDRW-1:0]             rqaddr,
   input  logic                         rqvalid,
   output logic                         rqready,
   output logic [DATAW-1:0]             rddata,
   output logic                         rderr,
   output logic                         rdvalid,
   input  logic                         rdready,
   output logic [DEPTH*DATAW-1:0]       mem_expose,
   output logic [DEPTH-1:0]             upd
);

   // One extra bit so DEPTH == 2**ADDRW is representable.
   localparam logic [ADDRW:0] DEPTH_W = (ADDRW + 1)'(DEPTH);

   logic [DATAW-1:0] reg_val [DEPTH];
   logic             wr_in_range, rd_in_range, rq_fire;
   logic [DATAW-1:0] rd_mux;

   logic             rdvalid_q, rdvalid_d;
   logic             rderr_q,   rderr_d;
   logic [DATAW-1:0] rddata_q,  rddata_d;
   logic             wrerr_q,   wrerr_d;

   assign wr_in_range = ({1'b0, wraddr} < DEPTH_W);
   assign rd_in_range = ({1'b0, rqaddr} < DEPTH_W);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      otl_cfg_reg #(
         .DATAW  (DATAW),
         .RSTVAL (RSTVAL[gi*DATAW +: DATAW]),
         .WRMASK (WRMASK[gi*DATAW +: DATAW])
      ) u_reg (
         .clk      (clk),
         .reset_n  (reset_n),
         .we_i     (wrvalid && wr_in_range && (wraddr == ADDRW'(gi))),
         .wrdata_i (wrdata),
         .wrstrb_i (wrstrb),
         .q_o      (reg_val[gi]),
         .upd_o    (upd[gi])
      );
      assign mem_expose[gi*DATAW +: DATAW] = reg_val[gi];
   end

   // Out-of-range addresses match no register, so they read as zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rqaddr == ADDRW'(i)) rd_mux = reg_val[i];
      end
   end

   // A held response blocks new requests; a retiring one lets the next in.
   assign rqready = !rdvalid_q || rdready;
   assign rq_fire = rqvalid && rqready;

   always_comb begin
      rdvalid_d = rdvalid_q;
      rderr_d   = rderr_q;
      rddata_d  = rddata_q;
      wrerr_d   = wrvalid && !wr_in_range;
      if (rq_fire) begin
         rdvalid_d = 1'b1;
         rddata_d  = rd_mux;
         rderr_d   = !rd_in_range;
      end else if (rdready) begin
         rdvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdvalid_q <= 1'b0;
         rderr_q   <= 1'b0;
         rddata_q  <= '0;
         wrerr_q   <= 1'b0;
      end else begin
         rdvalid_q <= rdvalid_d;
         rderr_q   <= rderr_d;
         rddata_q  <= rddata_d;
         wrerr_q   <= wrerr_d;
      end
   end

   assign wrready = 1'b1;
   assign wrerr   = wrerr_q;
   assign rdvalid = rdvalid_q;
   assign rderr   = rderr_q;
   assign rddata  = rddata_q;

endmodule

// File: doc/otl_cfg_regfile.md
# otl_cfg_regfile

Parametrised configuration register file for OTL cores: a host-facing write channel with byte strobes, a valid/ready read request/response channel, per-register reset values and writable-bit masks, and a flat exposure bus plus per-register update pulses that feed datapath logic. It sits between the host/bus adapter and the core datapath, alongside the existing single-port config memory, and is the block new cores instantiate for their control and status registers.

## Interface
- DATAW, 32, register width; must be a multiple of 8
- ADDRW, 4, address width
- DEPTH, 16, number of registers; 1 ≤ DEPTH ≤ 2^ADDRW
- RSTVAL, 0, flat DEPTH*DATAW reset image; register i is bits [i*DATAW +: DATAW]
- WRMASK, all ones, flat DEPTH*DATAW; 1 = host-writable bit, 0 = read-only bit, which holds RSTVAL
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- wraddr  in  ADDRW  write address
- wrdata  in  DATAW  write data
- wrstrb  in  DATAW/8  byte enables
- wrvalid  in  1  write request
- wrready  out  1  write accepted; constant 1
- wrerr  out  1  one-cycle pulse: previous accepted write was out of range
- rqaddr  in  ADDRW  read address
- rqvalid  in  1  read request
- rqready  out  1  read request accepted
- rddata  out  DATAW  read response data
- rderr  out  1  response qualifier: address was out of range
- rdvalid  out  1  response valid
- rdready  in  1  response accepted
- mem_expose  out  DEPTH*DATAW  flat live register contents
- upd  out  DEPTH  one-cycle pulse per register written

## Operation
- Write: on clk with wrvalid=1 and wraddr<DEPTH, byte b of register wraddr takes wrdata byte b where wrstrb[b]=1 AND the WRMASK bit is 1; all other bits are unchanged.
- upd[i] pulses for exactly one cycle after any accepted in-range write to i with at least one strobe set, even if the value is unchanged.
- Out-of-range write (wraddr ≥ DEPTH): no state change, no upd; wrerr=1 on the next cycle.
- Read: request handshake occurs when rqvalid && rqready. rqready = !rdvalid || rdready, so back-to-back reads run at full rate.
- On handshake, the next cycle has rdvalid=1 and rddata = register[rqaddr] as it stood before any same-edge write (old data). rderr=1 and rddata=0 if rqaddr ≥ DEPTH.
- Hold: while rdvalid && !rdready, rddata and rderr are frozen and no new request is accepted.
- Without a new handshake, the cycle in which rdready=1 retires the response: rdvalid falls on the next edge.
- mem_expose reflects register contents one cycle after the write edge.
- Reset (asynchronous, any time, including mid-hold): registers load RSTVAL. rdvalid, rderr, wrerr and upd are 0; rddata is 0. A pending response is discarded.

## Timing
- Write to mem_expose and upd: 1 cycle. Read request to response: 1 cycle. Sustained throughput is 1 write and 1 read per cycle, concurrently.
- Simultaneous write and read to the same address in one cycle: the read returns the old value. A read issued the following cycle returns the new value.
- Reset release: the first request is accepted on the first edge with reset_n=1. rqready=1 out of reset.

## Structure
- Package otl_cfg_pkg holds the strobe-width function (DATAW/8) and a mask-merge function (old, new, strobe, wrmask). These are shared with the bus adapters.
- Sub-module otl_cfg_reg: one register with strobe/mask merge, RSTVAL load and upd generation. It is instantiated DEPTH times by generate.
- The top level holds the read mux, response register and error logic.

## Test plan
- Reset with RSTVAL[reg 2]=0x0000_00A5: read addr 2 → rdvalid next cycle, rddata=0x0000_00A5, rderr=0.
- WRMASK[reg 1]=0x0000_FFFF, reset 0; write 0xDEAD_BEEF with strobe 0xF → reg1=0x0000_BEEF and upd[1] pulses once; then strobe 0x1, data 0x0000_0012 → reg1=0x0000_BE12.
- Same-cycle write 0x1111_1111 and read of reg 3 (holding 0) → rddata=0; next read → 0x1111_1111.
- DEPTH=12, ADDRW=4: write addr 13 → wrerr pulse, no upd, no state change; read addr 13 → rderr=1, rddata=0.
- Back-to-back reads of addrs 0,1,2 with rdready low for 3 cycles on the second response → rqready=0 during the hold, rddata stable, and responses arrive in order with no loss or duplication.
- Assert reset_n mid-hold with reg0 written to 0x5 → rdvalid=0 immediately; reg0 returns to RSTVAL asynchronously.
